dart_scorer: RTL

DART_SCORER -- requirements
Module: dart_scorer

---
 rtl/dart_scorer_if.sv | 26 ++
 rtl/dart_scorer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dart_scorer_if.sv
// Dart input and score/result bus of the dart scorer.
// The scorer attaches through the slave modport; a dart source/observer uses master.
interface dart_scorer_if;
    logic       dart_come_i;
    logic [7:0] dart_position_x_i;
    logic [7:0] dart_position_y_i;
    logic       game_set_o;
    logic       player_1_done_o;
    logic       player_2_done_o;
    logic       player_1_win_o;
    logic       player_2_win_o;
    logic [8:0] player_1_pt_o;
    logic [8:0] player_2_pt_o;

    modport slave (
        input  dart_come_i, dart_position_x_i, dart_position_y_i,
        output game_set_o, player_1_done_o, player_2_done_o,
               player_1_win_o, player_2_win_o, player_1_pt_o, player_2_pt_o
    );

    modport master (
        output dart_come_i, dart_position_x_i, dart_position_y_i,
        input  game_set_o, player_1_done_o, player_2_done_o,
               player_1_win_o, player_2_win_o, player_1_pt_o, player_2_pt_o
    );
endinterface

// File: rtl/dart_scorer.sv
// Two-player count-down dart scorer: samples a dart, scores it against the board
// geometry in a short pipeline, applies turn/bust/win rules, pulses done per dart.
module dart_scorer #(
    parameter int unsigned START_PT = 301,
    parameter int unsigned HOLD_CYC = 4
) (
    input logic          clk,
    input logic          reset,
    dart_scorer_if.slave bus
);

    localparam int unsigned   HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [8:0]    START_V   = 9'(START_PT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_SCORE, S_UPDATE, S_DONE, S_HOLD, S_OVER
    } state_t;

    state_t        state_q, state_d;
    logic          player_q, player_d;   // 0 = player 1, 1 = player 2
    logic          thr_q, thr_d;         // player who threw the dart being reported
    logic [1:0]    darts_q, darts_d;
    logic [8:0]    snap_q, snap_d;
    logic [8:0]    pt1_q, pt1_d, pt2_q, pt2_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          win1_q, win1_d, win2_q, win2_d, gs_q, gs_d;
    logic          done1_q, done1_d, done2_q, done2_d;

    logic [7:0]  x_q, y_q;
    logic        miss_q;
    logic [11:0] r2_q;
    logic [4:0]  base_q;
    logic [5:0]  score_q;

    logic signed [11:0] dx, dy, sqx, sqy;
    logic [11:0] r2_w;
    logic [8:0]  sum_xy;
    logic [4:0]  base_w;

    function automatic logic [5:0] ring_score(input logic        miss,
                                              input logic [11:0] r2,
                                              input logic [4:0]  base);
        logic [5:0] b;
        b = {1'b0, base};
        if (miss)                             return 6'd0;
        else if (r2 <= 12'd1)                 return 6'd50;
        else if (r2 <= 12'd9)                 return 6'd25;
        else if (r2 > 12'd225)                return 6'd0;
        else if (r2 >= 12'd100 && r2 <= 12'd121) return b * 6'd3;
        else if (r2 >= 12'd196)               return b + b;
        else                                  return b;
    endfunction

    // Sample stage: only the low 5 bits matter once a miss is excluded.
    assign dx     = $signed({7'd0, x_q[4:0]}) - 12'sd16;
    assign dy     = $signed({7'd0, y_q[4:0]}) - 12'sd16;
    assign sqx    = dx * dx;
    assign sqy    = dy * dy;
    assign r2_w   = sqx + sqy;
    assign sum_xy = 9'(x_q) + 9'(y_q);
    assign base_w = 5'((sum_xy % 9'd20) + 9'd1);

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.dart_come_i) begin
            x_q <= bus.dart_position_x_i;
            y_q <= bus.dart_position_y_i;
        end
        // SAMPLE -> SCORE boundary
        if (state_q == S_SAMPLE) begin
            miss_q <= (x_q[7:5] != 3'd0) || (y_q[7:5] != 3'd0);
            r2_q   <= r2_w;
            base_q <= base_w;
        end
        // SCORE -> UPDATE boundary
        if (state_q == S_SCORE) begin
            score_q <= ring_score(miss_q, r2_q, base_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            player_q <= 1'b0;
            thr_q    <= 1'b0;
            darts_q  <= 2'd0;
            snap_q   <= START_V;
            pt1_q    <= START_V;
            pt2_q    <= START_V;
            hold_q   <= '0;
            win1_q   <= 1'b0;
            win2_q   <= 1'b0;
            gs_q     <= 1'b0;
            done1_q  <= 1'b0;
            done2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            thr_q    <= thr_d;
            darts_q  <= darts_d;
            snap_q   <= snap_d;
            pt1_q    <= pt1_d;
            pt2_q    <= pt2_d;
            hold_q   <= hold_d;
            win1_q   <= win1_d;
            win2_q   <= win2_d;
            gs_q     <= gs_d;
            done1_q  <= done1_d;
            done2_q  <= done2_d;
        end
    end

    logic [8:0] cur_pt, new_pt, score9;
    logic       end_turn;

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        thr_d    = thr_q;
        darts_d  = darts_q;
        snap_d   = snap_q;
        pt1_d    = pt1_q;
        pt2_d    = pt2_q;
        hold_d   = hold_q;
        win1_d   = win1_q;
        win2_d   = win2_q;
        gs_d     = gs_q;
        done1_d  = 1'b0;
        done2_d  = 1'b0;
        cur_pt   = player_q ? pt2_q : pt1_q;
        new_pt   = cur_pt;
        score9   = {3'd0, score_q};
        end_turn = 1'b0;

        case (state_q)
            S_IDLE:   if (bus.dart_come_i) state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_SCORE;
            S_SCORE:  state_d = S_UPDATE;
            S_UPDATE: begin
                thr_d = player_q;
                if (score9 < cur_pt) begin
                    new_pt   = cur_pt - score9;
                    end_turn = (darts_q == 2'd2);
                end else if (score9 == cur_pt) begin
                    new_pt   = 9'd0;
                    end_turn = 1'b1;
                    gs_d     = 1'b1;
                    if (player_q) win2_d = 1'b1;
                    else          win1_d = 1'b1;
                end else begin
                    // Bust: the whole turn is undone.
                    new_pt   = snap_q;
                    end_turn = 1'b1;
                end
                if (player_q) pt2_d = new_pt;
                else          pt1_d = new_pt;
                if (end_turn) begin
                    player_d = ~player_q;
                    darts_d  = 2'd0;
                    snap_d   = player_q ? pt1_q : pt2_q;
                end else begin
                    darts_d  = darts_q + 2'd1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done1_d = ~thr_q;
                done2_d = thr_q;
                hold_d  = '0;
                state_d = gs_q ? S_OVER : S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) state_d = S_IDLE;
                else                     hold_d  = hold_q + 1'b1;
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.game_set_o      = gs_q;
    assign bus.player_1_done_o = done1_q;
    assign bus.player_2_done_o = done2_q;
    assign bus.player_1_win_o  = win1_q;
    assign bus.player_2_win_o  = win2_q;
    assign bus.player_1_pt_o   = pt1_q;
    assign bus.player_2_pt_o   = pt2_q;

endmodule
